draw_addr_gen: RTL and testbench
================================

Name: draw_addr_gen

Overview:
- Parametrised multi-lane address generator for the draw path. Emits LANES consecutive, interleaved pixel/memory addresses per beat over a programmable group range.
- Generalises the fixed-range, two-lane even/odd counter: run-time base and length, LANES-wide interleave, a valid/ready output handshake, start/done/abort control and an optional loop mode.
- Sits between the draw controller (start/base/count) and the frame-buffer write/read ports (one address per lane).

Parameters:
ADDR_W, 14, width of each lane address.
LANES, 2, addresses per beat; must be a power of two with 1 <= LANES <= 8; LG = log2(LANES).
GRP_W, ADDR_W-LG (derived localparam), width of the group index.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  pulse; begins a run when the block is IDLE.
base_grp  input  GRP_W  first group index; sampled on an accepted start.
grp_count  input  GRP_W  number of groups in the run; sampled on an accepted start.
loop_mode  input  1  1 = restart from base after the last group; sampled on an accepted start.
abort  input  1  terminates the run; priority over all other controls.
out_ready  input  1  downstream accepts the current beat.
addr_o  output  LANES*ADDR_W  packed addresses; lane k occupies bits [k*ADDR_W +: ADDR_W].
addr_valid  output  1  addr_o holds a valid beat.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse when a one-shot run ends.

Behaviour:
- Address rule: lane k = {grp[GRP_W-1:0], k[LG-1:0]}, where grp = (base_r + idx) mod 2^GRP_W. The group index wraps silently at 2^GRP_W.
- Internal registers: base_r, cnt_r, loop_r, and idx (GRP_W bits, counts 0..cnt_r-1).
- Reset (asynchronous, reset=0):
  - state = IDLE.
  - idx, base_r, cnt_r and loop_r = 0.
  - addr_valid = 0, busy = 0, done = 0.
  - addr_o = 0 (the lane-index bits of addr_o are constant and show k).
- IDLE:
  - start=1 and grp_count!=0: latch base/count/mode, set idx=0, go to RUN. addr_valid rises the next cycle, giving one cycle of latency from start.
  - start=1 and grp_count==0: go to DONE; no beats are emitted.
  - start=0: remain in IDLE.
- RUN:
  - addr_valid=1 throughout.
  - A transfer occurs when addr_valid and out_ready are both 1.
  - Without a transfer, addr_o and idx hold stable.
  - Transfer with idx < cnt_r-1: idx increments by 1.
  - Transfer with idx == cnt_r-1 and loop_r=1: idx = 0 and the block stays in RUN. There is no bubble: the next beat is at base in the following cycle.
  - Transfer with idx == cnt_r-1 and loop_r=0: go to DONE, and addr_valid drops the next cycle.
- DONE: lasts one cycle. done=1, addr_valid=0, busy=1. Then go to IDLE.
- abort=1 in any state:
  - Next state is IDLE; addr_valid, busy and done are 0 the next cycle.
  - No done pulse is generated.
  - A beat that transfers in the same cycle as abort counts as delivered.
  - abort and start in the same cycle: abort wins; start is ignored.
- start while busy (RUN or DONE) is ignored; the latched registers do not change.
- Changes on base_grp, grp_count or loop_mode outside an accepted start have no effect.
- An asynchronous reset mid-run returns all state to the reset values immediately. No partial done is generated.

Test Plan:
- Basic run: LANES=2, ADDR_W=14, base_grp=7296, grp_count=128, loop_mode=0, out_ready=1 → 128 beats.
  - First beat {14592,14593}, last beat {14846,14847}.
  - addr_valid high for 128 consecutive cycles starting 1 cycle after start.
  - done pulses once, 1 cycle after the last beat.
- Backpressure: same run with out_ready toggled 1,0,0,1 repeating → addr_o stable while ready=0, no skipped or duplicated beats, still exactly 128 beats.
- Loop and wrap: LANES=4, base_grp=4094, grp_count=3, loop_mode=1 → groups 4094, 4095, 0, 4094, ….
  - Lane-0 addresses are 16376, 16380, 0, 16376.
  - done never asserts.
  - abort then yields IDLE with addr_valid=0 on the next cycle.
- Zero count: start with grp_count=0 → no valid beat, done pulses on the cycle after start, busy high for exactly 1 cycle.
- Control collisions:
  - start during RUN → ignored; sequence unchanged.
  - start and abort in the same IDLE cycle → stays IDLE.
- Mid-run reset: assert reset=0 after 10 beats → all outputs 0 asynchronously. A new start afterwards begins again from its new base.

Source files
------------

// File: rtl/draw_addr_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : draw_addr_gen_if                                                |
// | Brief  : Output beat bus of the draw address generator. Carries LANES    |
// |          packed lane addresses with a valid/ready handshake.             |
// | Ports  : addr_o     - packed lane addresses, lane k at [k*ADDR_W+:ADDR_W]|
// |          addr_valid - addr_o holds a valid beat (master -> slave)        |
// |          out_ready  - slave accepts the current beat (slave -> master)   |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
interface draw_addr_gen_if #(
   parameter int ADDR_W = 14,
   parameter int LANES  = 2
);
   logic [LANES*ADDR_W-1:0] addr_o;
   logic                    addr_valid;
   logic                    out_ready;

   modport master (output addr_o, output addr_valid, input  out_ready);
   modport slave  (input  addr_o, input  addr_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/draw_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : draw_addr_gen                                                   |
// | Brief  : Multi-lane interleaved address generator for the draw path.     |
// |          Emits LANES consecutive addresses per beat over a run of        |
// |          grp_count groups starting at base_grp, optionally looping.      |
// | Ports  : clk, reset (async, active-low)                                  |
// |          start/base_grp/grp_count/loop_mode - run request (IDLE only)    |
// |          abort     - ends the run, highest priority                      |
// |          bus       - master side of draw_addr_gen_if (addr/valid/ready)  |
// |          busy      - high in RUN and DONE                                |
// |          done      - one-cycle pulse at the end of a one-shot run        |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
// LANES must be a power of two in 1..8.
module draw_addr_gen #(
   parameter  int ADDR_W = 14,
   parameter  int LANES  = 2,
   localparam int LG     = $clog2(LANES),
   localparam int GRP_W  = ADDR_W - LG
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [GRP_W-1:0] base_grp,
   input  logic [GRP_W-1:0] grp_count,
   input  logic             loop_mode,
   input  logic             abort,
   draw_addr_gen_if.master  bus,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [GRP_W-1:0] base_q, base_d;
   logic [GRP_W-1:0] cnt_q, cnt_d;
   logic [GRP_W-1:0] idx_q, idx_d;
   logic             loop_q, loop_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             xfer;
   logic             last_beat;
   logic [GRP_W-1:0] grp;

   assign xfer      = valid_q & bus.out_ready;
   // cnt_q is never zero while in RUN, so cnt_q-1 cannot underflow there.
   assign last_beat = (idx_q == (cnt_q - GRP_W'(1)));
   // Group index wraps naturally at 2^GRP_W.
   assign grp       = base_q + idx_q;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      loop_d  = loop_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (abort) begin
         // A beat accepted in this same cycle has already been delivered;
         // nothing needs undoing.
         state_d = S_IDLE;
         valid_d = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  busy_d = 1'b1;
                  if (grp_count != '0) begin
                     base_d  = base_grp;
                     cnt_d   = grp_count;
                     loop_d  = loop_mode;
                     idx_d   = '0;
                     valid_d = 1'b1;
                     state_d = S_RUN;
                  end else begin
                     // Empty run: straight to the done pulse, no beats.
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end
               end
            end
            S_RUN: begin
               if (xfer) begin
                  if (!last_beat) begin
                     idx_d = idx_q + GRP_W'(1);
                  end else if (loop_q) begin
                     idx_d = '0;
                  end else begin
                     valid_d = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end
               end
            end
            S_DONE: begin
               busy_d  = 1'b0;
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         loop_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         loop_q  <= loop_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Lane k carries {grp, k}; the low LG bits are fixed per lane.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      if (LG == 0) begin : g_single
         assign bus.addr_o[k*ADDR_W +: ADDR_W] = grp;
      end else begin : g_multi
         assign bus.addr_o[k*ADDR_W +: ADDR_W] = {grp, LG'(k)};
      end
   end

   assign bus.addr_valid = valid_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_draw_addr_gen                                                |
// | Brief  : Self-checking bench for draw_addr_gen. Instance A uses LANES=2, |
// |          instance B uses LANES=4. Control vectors come from a table;     |
// |          beats are checked against a queue of expected addresses.        |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_draw_addr_gen;

   logic clk;
   logic reset;

   // Instance A: LANES=2, GRP_W=13
   logic        a_start, a_loop, a_abort, a_busy, a_done;
   logic [12:0] a_base, a_count;
   // Instance B: LANES=4, GRP_W=12
   logic        b_start, b_loop, b_abort, b_busy, b_done;
   logic [11:0] b_base, b_count;

   draw_addr_gen_if #(.ADDR_W(14), .LANES(2)) bus_a ();
   draw_addr_gen_if #(.ADDR_W(14), .LANES(4)) bus_b ();

   draw_addr_gen #(.ADDR_W(14), .LANES(2)) dut_a (
      .clk(clk), .reset(reset), .start(a_start), .base_grp(a_base),
      .grp_count(a_count), .loop_mode(a_loop), .abort(a_abort),
      .bus(bus_a), .busy(a_busy), .done(a_done));

   draw_addr_gen #(.ADDR_W(14), .LANES(4)) dut_b (
      .clk(clk), .reset(reset), .start(b_start), .base_grp(b_base),
      .grp_count(b_count), .loop_mode(b_loop), .abort(b_abort),
      .bus(bus_b), .busy(b_busy), .done(b_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;
   logic [63:0] q_a[$];
   logic [63:0] q_b[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Expected packed beat for group g: lane k = g*lanes + k.
   function automatic logic [63:0] beat(input int g, input int lanes);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < lanes; k++) r[k*14 +: 14] = 14'(g*lanes + k);
      return r;
   endfunction

   task automatic push_a(input int base, input int cnt);
      for (int i = 0; i < cnt; i++) q_a.push_back(beat((base + i) % 8192, 2));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: a transfer happens at the next rising edge whenever valid
   // and ready are both high; inputs are stable at the falling edge.
   always @(negedge clk) begin
      if (mon_en && bus_a.addr_valid && bus_a.out_ready) begin
         if (q_a.size() == 0) chk("a_unexpected_beat", {36'd0, bus_a.addr_o}, 64'hFFFF);
         else chk("a_beat", {36'd0, bus_a.addr_o}, q_a.pop_front());
      end
      if (mon_en && bus_b.addr_valid && bus_b.out_ready) begin
         if (q_b.size() == 0) chk("b_unexpected_beat", {8'd0, bus_b.addr_o}, 64'hFFFF);
         else chk("b_beat", {8'd0, bus_b.addr_o}, q_b.pop_front());
      end
   end

   typedef struct {
      logic        start;
      logic [12:0] base;
      logic [12:0] cnt;
      logic        abort;
      logic        ready;
      logic        ev, eb, ed;
      logic        ca;
      logic [27:0] ea;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int nval, ndone, done_at, last_v, xfers, p;
      logic [27:0] last_addr, prev_addr;
      logic prev_stall;
      bit seen_done;

      //            start base cnt abort rdy  ev   eb   ed   ca   ea
      tbl[0]  = '{1'b0, 13'd0,  13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {14'd1, 14'd0}};
      tbl[1]  = '{1'b1, 13'd9,  13'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0};
      tbl[2]  = '{1'b0, 13'd0,  13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0};
      tbl[3]  = '{1'b1, 13'd0,  13'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 28'd0};
      tbl[4]  = '{1'b0, 13'd0,  13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0};
      tbl[5]  = '{1'b1, 13'd10, 13'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, {14'd21, 14'd20}};
      tbl[6]  = '{1'b1, 13'd3,  13'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, {14'd21, 14'd20}};
      tbl[7]  = '{1'b0, 13'd0,  13'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, {14'd23, 14'd22}};
      tbl[8]  = '{1'b0, 13'd0,  13'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 28'd0};
      tbl[9]  = '{1'b0, 13'd0,  13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0};
      tbl[10] = '{1'b1, 13'd5,  13'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, {14'd11, 14'd10}};
      tbl[11] = '{1'b0, 13'd0,  13'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0};
      tbl[12] = '{1'b0, 13'd0,  13'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 28'd0};

      reset = 1'b0;
      a_start = 0; a_loop = 0; a_abort = 0; a_base = '0; a_count = '0;
      b_start = 0; b_loop = 0; b_abort = 0; b_base = '0; b_count = '0;
      bus_a.out_ready = 1'b0;
      bus_b.out_ready = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_a_ctl", {61'd0, bus_a.addr_valid, a_busy, a_done}, 64'd0);
      chk("rst_a_addr", {36'd0, bus_a.addr_o}, {36'd0, 14'd1, 14'd0});
      chk("rst_b_ctl", {61'd0, bus_b.addr_valid, b_busy, b_done}, 64'd0);
      chk("rst_b_addr", {8'd0, bus_b.addr_o}, {8'd0, 14'd3, 14'd2, 14'd1, 14'd0});
      #2 reset = 1'b1;
      tick();

      // Table-driven control vectors
      for (int i = 0; i < 13; i++) begin
         a_start = tbl[i].start; a_base = tbl[i].base; a_count = tbl[i].cnt;
         a_abort = tbl[i].abort; bus_a.out_ready = tbl[i].ready;
         tick();
         chk($sformatf("vec%0d_ctl", i), {61'd0, bus_a.addr_valid, a_busy, a_done},
             {61'd0, tbl[i].ev, tbl[i].eb, tbl[i].ed});
         if (tbl[i].ca) chk($sformatf("vec%0d_addr", i), {36'd0, bus_a.addr_o}, {36'd0, tbl[i].ea});
      end
      a_start = 0; a_abort = 0; bus_a.out_ready = 0;
      tick();

      // Basic run with a start pulse injected mid-run
      mon_en = 1'b1;
      a_base = 13'd7296; a_count = 13'd128; a_loop = 0; a_start = 1;
      bus_a.out_ready = 1'b1;
      push_a(7296, 128);
      tick();
      a_start = 0;
      chk("basic_first_beat", {36'd0, bus_a.addr_o}, {36'd0, 14'd14593, 14'd14592});
      nval = 0; ndone = 0; done_at = -1; last_v = -1; last_addr = '0;
      for (int c = 1; c <= 200; c++) begin
         if (bus_a.addr_valid) begin nval++; last_v = c; last_addr = bus_a.addr_o; end
         if (a_done) begin ndone++; done_at = c; end
         a_start = (c == 5);
         if (c == 5) begin a_base = 13'd0; a_count = 13'd1; a_loop = 1'b1; end
         tick();
      end
      a_start = 0; a_loop = 0;
      chk("basic_valid_cycles", 64'(nval), 64'd128);
      chk("basic_last_valid_cycle", 64'(last_v), 64'd128);
      chk("basic_last_beat", {36'd0, last_addr}, {36'd0, 14'd14847, 14'd14846});
      chk("basic_done_count", 64'(ndone), 64'd1);
      chk("basic_done_cycle", 64'(done_at), 64'd129);
      chk("basic_queue_empty", 64'(q_a.size()), 64'd0);

      // Backpressure: ready pattern 1,0,0,1 repeating
      a_base = 13'd7296; a_count = 13'd128; a_loop = 0; a_start = 1;
      push_a(7296, 128);
      tick();
      a_start = 0;
      xfers = 0; ndone = 0; p = 0; prev_stall = 0; prev_addr = '0; seen_done = 0;
      for (int c = 0; c < 600 && !seen_done; c++) begin
         if (prev_stall && bus_a.addr_valid) chk("bp_stable", {36'd0, bus_a.addr_o}, {36'd0, prev_addr});
         if (a_done) begin ndone++; seen_done = 1; end
         bus_a.out_ready = (p % 4 == 0) || (p % 4 == 3);
         p++;
         if (bus_a.addr_valid && bus_a.out_ready) xfers++;
         prev_stall = bus_a.addr_valid && !bus_a.out_ready;
         prev_addr  = bus_a.addr_o;
         tick();
      end
      chk("bp_finished_in_time", 64'(seen_done), 64'd1);
      chk("bp_transfers", 64'(xfers), 64'd128);
      chk("bp_queue_empty", 64'(q_a.size()), 64'd0);
      bus_a.out_ready = 1'b1;
      tick();

      // Mid-run reset after 10 beats
      a_base = 13'd100; a_count = 13'd50; a_start = 1;
      push_a(100, 50);
      tick();
      a_start = 0;
      for (int i = 0; i < 10; i++) tick();
      #2 reset = 1'b0;
      #1;
      chk("mrst_ctl", {61'd0, bus_a.addr_valid, a_busy, a_done}, 64'd0);
      chk("mrst_addr", {36'd0, bus_a.addr_o}, {36'd0, 14'd1, 14'd0});
      q_a.delete();
      tick();
      #3 reset = 1'b1;
      tick();
      a_base = 13'd200; a_count = 13'd4; a_start = 1;
      push_a(200, 4);
      tick();
      a_start = 0;
      chk("mrst_restart_beat", {36'd0, bus_a.addr_o}, {36'd0, 14'd401, 14'd400});
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         if (a_done) ndone++;
         tick();
      end
      chk("mrst_restart_done", 64'(ndone), 64'd1);
      chk("mrst_queue_empty", 64'(q_a.size()), 64'd0);

      // Loop and wrap on the 4-lane instance, ended by abort
      b_base = 12'd4094; b_count = 12'd3; b_loop = 1; b_start = 1;
      bus_b.out_ready = 1'b1;
      for (int i = 0; i < 7; i++) q_b.push_back(beat((4094 + (i % 3)) % 4096, 4));
      tick();
      b_start = 0; b_loop = 0;
      ndone = 0;
      for (int i = 0; i < 7; i++) begin
         if (b_done) ndone++;
         chk($sformatf("loop_valid%0d", i), {63'd0, bus_b.addr_valid}, 64'd1);
         b_abort = (i == 6);
         tick();
      end
      b_abort = 0;
      chk("loop_no_done", 64'(ndone), 64'd0);
      chk("loop_abort_ctl", {61'd0, bus_b.addr_valid, b_busy, b_done}, 64'd0);
      tick();
      chk("loop_abort_idle", {61'd0, bus_b.addr_valid, b_busy, b_done}, 64'd0);
      chk("loop_queue_empty", 64'(q_b.size()), 64'd0);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
